// File: rtl/input_width_transform.sv
// Receive-side width converter: packs an 8-bit byte stream into 134-bit words
// ({code[1:0], invalid[3:0], 16 bytes}) for the forwarding core's input FIFO.
module input_width_transform #(
  parameter logic [6:0] PKT_ADMIT_USEDW = 7'd32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [7:0]   iv_data,
  input  logic         i_data_wr,
  input  logic [6:0]   iv_fifo_usedw,
  output logic [133:0] ov_data,
  output logic         o_data_wr,
  output logic         o_pkt_discard_pulse,
  output logic         o_short_pkt_pulse
);

  typedef enum logic [1:0] {IDLE, ACC, DISC, TAIL} state_t;

  localparam logic [1:0] CODE_HEAD = 2'b01;
  localparam logic [1:0] CODE_MID  = 2'b11;
  localparam logic [1:0] CODE_TAIL = 2'b10;

  state_t         state_q, state_d;
  logic [127:0]   acc_q, acc_d, acc_ins;
  logic [127:0]   hold_q, hold_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           hold_vld_q, hold_vld_d;
  logic           first_q, first_d;
  logic [133:0]   data_d;
  logic           wr_d, disc_d, short_d;

  // Slot 0 is the most significant byte, so the first byte lands in [127:120].
  function automatic logic [127:0] put_byte(input logic [127:0] w, input logic [3:0] idx,
                                            input logic [7:0] b);
    logic [127:0] r;
    r = w;
    r[8*(15-int'(idx)) +: 8] = b;
    return r;
  endfunction

  // Slots from n upward still hold bytes of an earlier word; zero them for the tail.
  function automatic logic [127:0] tail_bytes(input logic [127:0] w, input logic [3:0] n);
    logic [127:0] r;
    r = w;
    for (int i = 0; i < 16; i++) begin
      if (i >= int'(n)) r[8*(15-i) +: 8] = 8'd0;
    end
    return r;
  endfunction

  assign acc_ins = put_byte(acc_q, cnt_q, iv_data);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    first_d    = first_q;
    data_d     = ov_data;
    wr_d       = 1'b0;
    disc_d     = 1'b0;
    short_d    = 1'b0;
    case (state_q)
      IDLE, TAIL: begin
        if (state_q == TAIL) begin
          data_d = {CODE_TAIL, 4'd0 - cnt_q, tail_bytes(acc_q, cnt_q)};
          wr_d   = 1'b1;
        end
        state_d    = IDLE;
        cnt_d      = 4'd0;
        hold_vld_d = 1'b0;
        first_d    = 1'b0;
        // A byte here starts a new packet; admission is decided only now.
        if (i_data_wr) begin
          if (iv_fifo_usedw <= PKT_ADMIT_USEDW) begin
            acc_d   = put_byte(acc_q, 4'd0, iv_data);
            cnt_d   = 4'd1;
            first_d = 1'b1;
            state_d = ACC;
          end else begin
            state_d = DISC;
          end
        end
      end
      ACC: begin
        if (i_data_wr) begin
          acc_d = acc_ins;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            if (hold_vld_q) begin
              data_d  = {first_q ? CODE_HEAD : CODE_MID, 4'd0, hold_q};
              wr_d    = 1'b1;
              first_d = 1'b0;
            end
            hold_d     = acc_ins;
            hold_vld_d = 1'b1;
          end
        end else if (!hold_vld_q || (first_q && cnt_q == 4'd0)) begin
          // Sixteen bytes or fewer: a single held word with first_flag still set.
          short_d    = 1'b1;
          state_d    = IDLE;
          cnt_d      = 4'd0;
          hold_vld_d = 1'b0;
          first_d    = 1'b0;
        end else if (cnt_q == 4'd0) begin
          data_d     = {CODE_TAIL, 4'd0, hold_q};
          wr_d       = 1'b1;
          state_d    = IDLE;
          hold_vld_d = 1'b0;
          first_d    = 1'b0;
        end else begin
          data_d     = {first_q ? CODE_HEAD : CODE_MID, 4'd0, hold_q};
          wr_d       = 1'b1;
          first_d    = 1'b0;
          hold_vld_d = 1'b0;
          state_d    = TAIL;
        end
      end
      DISC: begin
        if (!i_data_wr) begin
          disc_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q             <= IDLE;
      cnt_q               <= 4'd0;
      hold_vld_q          <= 1'b0;
      first_q             <= 1'b0;
      ov_data             <= '0;
      o_data_wr           <= 1'b0;
      o_pkt_discard_pulse <= 1'b0;
      o_short_pkt_pulse   <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      hold_vld_q          <= hold_vld_d;
      first_q             <= first_d;
      ov_data             <= data_d;
      o_data_wr           <= wr_d;
      o_pkt_discard_pulse <= disc_d;
      o_short_pkt_pulse   <= short_d;
    end
  end

  always_ff @(posedge i_clk) begin
    acc_q  <= acc_d;
    hold_q <= hold_d;
  end

endmodule

// File: tb/tb_input_width_transform.sv
// Directed bench for input_width_transform: packet table plus back-to-back and reset sequences.
module tb_input_width_transform;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [7:0]   iv_data;
  logic         i_data_wr;
  logic [6:0]   iv_fifo_usedw;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic         o_pkt_discard_pulse;
  logic         o_short_pkt_pulse;

  input_width_transform dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .iv_data            (iv_data),
    .i_data_wr          (i_data_wr),
    .iv_fifo_usedw      (iv_fifo_usedw),
    .ov_data            (ov_data),
    .o_data_wr          (o_data_wr),
    .o_pkt_discard_pulse(o_pkt_discard_pulse),
    .o_short_pkt_pulse  (o_short_pkt_pulse)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [133:0] wq[$];
  int           wcyc[$];
  int           n_short = 0;
  int           n_disc  = 0;
  always @(negedge i_clk) begin
    if (o_data_wr) begin
      wq.push_back(ov_data);
      wcyc.push_back(cyc);
    end
    if (o_short_pkt_pulse)   n_short++;
    if (o_pkt_discard_pulse) n_disc++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [133:0] act, input logic [133:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference word j of a packet of len bytes whose byte k is (base+k).
  function automatic logic [133:0] exp_word(input int len, input int base, input int j);
    int           n;
    int           nb;
    logic [1:0]   code;
    logic [3:0]   inv;
    logic [127:0] d;
    n  = (len + 15) / 16;
    nb = len - 16 * j;
    if (nb > 16) nb = 16;
    code = (j == 0) ? 2'b01 : ((j == n - 1) ? 2'b10 : 2'b11);
    inv  = (j == n - 1) ? 4'(16 - nb) : 4'd0;
    d    = '0;
    for (int b = 0; b < nb; b++) d[8*(15-b) +: 8] = 8'(base + 16 * j + b);
    return {code, inv, d};
  endfunction

  // Drives len bytes then one low cycle; last_cyc is the edge count that sampled the last byte.
  task automatic send(input int len, input int base, input int u0, input int umid,
                      output int last_cyc);
    for (int k = 0; k < len; k++) begin
      @(negedge i_clk);
      iv_data       = 8'(base + k);
      i_data_wr     = 1'b1;
      iv_fifo_usedw = (k == 0) ? 7'(u0) : 7'(umid);
    end
    @(negedge i_clk);
    i_data_wr     = 1'b0;
    iv_data       = 8'd0;
    iv_fifo_usedw = 7'd0;
    last_cyc      = cyc;
  endtask

  typedef struct {
    int len; int base; int u0; int umid;
    int words; int inv; int lat; int shorts; int discs;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int s0, sh0, d0, lc, nw;
    vecs[0]  = '{64,   0,   0,   0, 4,  0, 1, 0, 0};
    vecs[1]  = '{60,   0,   0,   0, 4,  4, 2, 0, 0};
    vecs[2]  = '{17,   0,   0,   0, 2, 15, 2, 0, 0};
    vecs[3]  = '{16,   0,   0,   0, 0,  0, 0, 1, 0};
    vecs[4]  = '{5,   32,   0,   0, 0,  0, 0, 1, 0};
    vecs[5]  = '{64,   0,  33,   0, 0,  0, 0, 0, 1};
    vecs[6]  = '{64,  16,  32, 100, 4,  0, 1, 0, 0};
    vecs[7]  = '{32, 200,   5,   5, 2,  0, 1, 0, 0};
    vecs[8]  = '{1,    9,   0,   0, 0,  0, 0, 1, 0};
    vecs[9]  = '{48,   0, 127,   0, 0,  0, 0, 0, 1};
    vecs[10] = '{33,  77,   0,  90, 3, 15, 2, 0, 0};

    i_rst_n = 1'b0; iv_data = 8'd0; i_data_wr = 1'b0; iv_fifo_usedw = 7'd0;
    repeat (3) @(negedge i_clk);
    check_word("reset_ov_data", ov_data, 134'd0);
    check_int("reset_wr", int'(o_data_wr), 0);
    check_int("reset_pulses", int'(o_pkt_discard_pulse) + int'(o_short_pkt_pulse), 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int v = 0; v < 11; v++) begin
      s0 = wq.size(); sh0 = n_short; d0 = n_disc;
      send(vecs[v].len, vecs[v].base, vecs[v].u0, vecs[v].umid, lc);
      repeat (6) @(negedge i_clk);
      nw = wq.size() - s0;
      check_int($sformatf("v%0d_words", v), nw, vecs[v].words);
      check_int($sformatf("v%0d_short", v), n_short - sh0, vecs[v].shorts);
      check_int($sformatf("v%0d_disc", v), n_disc - d0, vecs[v].discs);
      if (nw == vecs[v].words && nw > 0) begin
        for (int j = 0; j < nw; j++)
          check_word($sformatf("v%0d_w%0d", v, j), wq[s0 + j],
                     exp_word(vecs[v].len, vecs[v].base, j));
        check_int($sformatf("v%0d_inv", v), int'(wq[s0 + nw - 1][131:128]), vecs[v].inv);
        check_int($sformatf("v%0d_lat", v), wcyc[s0 + nw - 1] - lc, vecs[v].lat);
      end
    end

    // Two maximum-size frames separated by a 12-cycle gap.
    s0 = wq.size();
    send(1518, 0, 0, 0, lc);
    repeat (11) @(negedge i_clk);
    send(1518, 7, 20, 120, lc);
    repeat (6) @(negedge i_clk);
    check_int("b2b_words", wq.size() - s0, 190);
    if (wq.size() - s0 == 190) begin
      for (int j = 0; j < 95; j++) begin
        check_word($sformatf("b2b_p0_w%0d", j), wq[s0 + j], exp_word(1518, 0, j));
        check_word($sformatf("b2b_p1_w%0d", j), wq[s0 + 95 + j], exp_word(1518, 7, j));
      end
      check_int("b2b_inv", int'(wq[s0 + 189][131:128]), 2);
      check_int("b2b_lat", wcyc[s0 + 189] - lc, 2);
    end

    // Reset asserted mid-packet at byte 40.
    sh0 = n_short; d0 = n_disc;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      iv_data = 8'(k); i_data_wr = 1'b1; iv_fifo_usedw = 7'd0;
    end
    #2 i_rst_n = 1'b0;
    #1;
    check_word("rst_mid_ov_data", ov_data, 134'd0);
    check_int("rst_mid_wr", int'(o_data_wr), 0);
    i_data_wr = 1'b0; iv_data = 8'd0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check_int("rst_mid_no_pulses", (n_short - sh0) + (n_disc - d0), 0);
    s0 = wq.size();
    send(64, 64, 0, 0, lc);
    repeat (6) @(negedge i_clk);
    check_int("post_rst_words", wq.size() - s0, 4);
    if (wq.size() - s0 == 4) begin
      for (int j = 0; j < 4; j++)
        check_word($sformatf("post_rst_w%0d", j), wq[s0 + j], exp_word(64, 64, j));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
